// File: rtl/regfile_dbg_pkg.sv
// Shared types for the register-file debug port.
// Holds the FSM state enum, default widths and the request latch.
package regfile_dbg_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NREGS  = 32;

   typedef enum logic [1:0] {
      IDLE,
      HALT,
      ACCESS,
      RESP
   } state_e;

   typedef struct packed {
      logic                  write;
      logic                  dump;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } req_lat_t;

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug access port: halts the core, then reads/writes one register
// (or, with REGFILE_DBG_DUMP_EN, dumps all of them) through the regfile
// ports and returns each result on a valid/ready response channel.
// Ports: clk/rst (sync, active-high); req_* request channel;
// rsp_* response channel; halt_req/halt_ack core stall handshake;
// rf_read_* / rf_write_* regfile access (read is combinational).
module regfile_dbg_port
   import regfile_dbg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREGS  = DEF_NREGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_dump,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              halt_req,
   input  logic              halt_ack,
   output logic [ADDR_W-1:0] rf_read_reg,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_en
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   state_e   state;
   req_lat_t lat;
   logic     we_q;
   logic     dump_in;

`ifdef REGFILE_DBG_DUMP_EN
   assign dump_in = req_dump;
`else
   logic unused_dump;
   assign unused_dump = req_dump;
   assign dump_in     = 1'b0;
`endif

   // A write racing a reset edge must not reach the regfile.
   assign rf_write_en = we_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         lat           <= '0;
         we_q          <= 1'b0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_addr      <= '0;
         rsp_data      <= '0;
         rsp_last      <= 1'b0;
         halt_req      <= 1'b0;
         rf_read_reg   <= '0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  lat.write <= req_write & ~dump_in;
                  lat.dump  <= dump_in;
                  lat.addr  <= dump_in ? '0 : req_addr;
                  lat.wdata <= req_wdata;
                  req_ready <= 1'b0;
                  halt_req  <= 1'b1;
                  state     <= HALT;
               end
            end
            HALT: begin
               if (halt_ack) begin
                  state <= ACCESS;
                  if (lat.write) begin
                     we_q          <= (lat.addr != '0);
                     rf_write_reg  <= lat.addr;
                     rf_write_data <= lat.wdata;
                  end else begin
                     rf_read_reg <= lat.addr;
                  end
               end
            end
            ACCESS: begin
               we_q          <= 1'b0;
               rf_read_reg   <= '0;
               rf_write_reg  <= '0;
               rf_write_data <= '0;
               rsp_valid     <= 1'b1;
               rsp_addr      <= lat.addr;
               rsp_last      <= lat.dump ? (lat.addr == LAST_IDX)
                                         : 1'b1;
               if (lat.addr == '0)
                  rsp_data <= '0;
               else if (lat.write)
                  rsp_data <= lat.wdata;
               else
                  rsp_data <= rf_read_data;
               state <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_last  <= 1'b0;
                  // Dump keeps the core halted and steps the index.
                  if (lat.dump && !rsp_last) begin
                     lat.addr    <= lat.addr + 1'b1;
                     rf_read_reg <= lat.addr + 1'b1;
                     state       <= ACCESS;
                  end else begin
                     halt_req  <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Self-checking bench for regfile_dbg_port with a behavioural regfile.
// Build with REGFILE_DBG_DUMP_EN to also exercise the dump sequence.
module tb_regfile_dbg_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_dump;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [4:0]  rsp_addr;
   logic [31:0] rsp_data;
   logic        halt_req, halt_ack;
   logic [4:0]  rf_read_reg, rf_write_reg;
   logic [31:0] rf_read_data, rf_write_data;
   logic        rf_write_en;

   int pass_cnt = 0;
   int total_cnt = 0;

   regfile_dbg_port dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_dump(req_dump),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .rsp_last(rsp_last),
      .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
      .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .rf_write_en(rf_write_en)
   );

   always #5 clk = ~clk;

   // Regfile without a hardwired x0, so the port must force zero.
   logic [31:0] rf [32];
   assign rf_read_data = (rf_read_reg == 5'd0) ? 32'hDEAD_BEEF
                                               : rf[rf_read_reg];
   int          we_cnt = 0;
   logic [4:0]  we_reg;
   always @(posedge clk) begin
      if (rf_write_en) begin
         rf[rf_write_reg] <= rf_write_data;
         we_cnt <= we_cnt + 1;
         we_reg <= rf_write_reg;
      end
   end

   // Reference: architectural register contents, x0 reads as 0.
   logic [31:0] ref_rf [32];

   function automatic logic [31:0] ref_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : ref_rf[a];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs();
      chk("rst_flags", {halt_req, rsp_valid, rf_write_en, rsp_last,
                        req_ready}, 5'b00001);
      chk("rst_rsp", {rsp_addr, rsp_data}, '0);
      chk("rst_rf", {rf_read_reg, rf_write_reg, rf_write_data}, '0);
   endtask

   // One single request: returns data, last, latency, write pulses.
   task automatic xact(input bit w, input bit d, input logic [4:0] a,
                       input logic [31:0] wd, input int ack_dly,
                       input int rdy_dly, output logic [31:0] rd,
                       output bit rl, output int lat, output int we_n);
      int   we0;
      int   cyc;
      bit   ok;
      logic [31:0] d0;
      we0 = we_cnt;
      cyc = 0;
      ok = 1'b1;
      req_write = w; req_dump = d; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      halt_ack = (ack_dly == 0);
      tick();
      req_valid = 1'b0;
      req_addr = 5'($urandom);
      req_wdata = $urandom;
      while (!rsp_valid && cyc < 64) begin
         if (!halt_req || req_ready) ok = 1'b0;
         if (cyc < ack_dly && (rf_write_en || rf_read_reg != 0))
            ok = 1'b0;
         halt_ack = (cyc >= ack_dly);
         tick();
         cyc++;
      end
      lat = cyc;
      chk("rsp_timeout", rsp_valid, 1'b1);
      chk("halt_phase", ok, 1'b1);
      chk("rsp_addr", rsp_addr, a);
      d0 = rsp_data;
      rl = rsp_last;
      halt_ack = 1'b0;
      ok = 1'b1;
      repeat (rdy_dly) begin
         tick();
         if (!rsp_valid || rsp_data !== d0 || rsp_addr !== a ||
             rsp_last !== rl || req_ready || !halt_req || rf_write_en)
            ok = 1'b0;
      end
      chk("rsp_stable", ok, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("back_idle", {rsp_valid, halt_req, req_ready}, 3'b001);
      rd = d0;
      we_n = we_cnt - we0;
   endtask

   typedef struct {
      bit          w;
      logic [4:0]  a;
      logic [31:0] wd;
      int          ack;
      int          rdy;
      logic [31:0] exp_d;
      int          exp_we;
   } vec_t;

   vec_t tbl[9];

   initial begin
      logic [31:0] rd;
      bit          rl;
      int          lat, wn, we0;
      bit          w, d;
      logic [4:0]  a;
      logic [31:0] wd;

      tbl[0] = '{1, 10, 12983,        0, 0, 12983,        1};
      tbl[1] = '{0, 10, 0,            0, 0, 12983,        0};
      tbl[2] = '{1, 0,  500,          0, 0, 0,            0};
      tbl[3] = '{0, 0,  0,            0, 0, 0,            0};
      tbl[4] = '{1, 30, 324,          0, 0, 324,          1};
      tbl[5] = '{0, 30, 0,            5, 0, 324,          0};
      tbl[6] = '{0, 30, 0,            0, 4, 324,          0};
      tbl[7] = '{1, 31, 32'hFFFFFFFF, 2, 1, 32'hFFFFFFFF, 1};
      tbl[8] = '{0, 31, 0,            1, 2, 32'hFFFFFFFF, 0};

      rst = 1'b1;
      req_valid = 0; req_write = 0; req_dump = 0;
      req_addr = 0; req_wdata = 0;
      rsp_ready = 0; halt_ack = 0;
      repeat (3) tick();
      chk_reset_outs();
      rst = 1'b0;
      tick();

      // Known contents for every register.
      for (int i = 1; i < 32; i++) begin
         wd = $urandom;
         xact(1, 0, 5'(i), wd, 0, 0, rd, rl, lat, wn);
         ref_rf[i] = wd;
      end
      chk("preload_rd", 64'(ref_rd(5'd17)), 64'(ref_rf[17]));

      for (int i = 0; i < 9; i++) begin
         xact(tbl[i].w, 0, tbl[i].a, tbl[i].wd, tbl[i].ack,
              tbl[i].rdy, rd, rl, lat, wn);
         chk($sformatf("v%0d_data", i), rd, tbl[i].exp_d);
         chk($sformatf("v%0d_last", i), rl, 1'b1);
         chk($sformatf("v%0d_we", i), wn, tbl[i].exp_we);
         chk($sformatf("v%0d_lat", i), lat, tbl[i].ack + 2);
         if (tbl[i].exp_we == 1)
            chk($sformatf("v%0d_wreg", i), we_reg, tbl[i].a);
         if (tbl[i].w && tbl[i].a != 0) ref_rf[tbl[i].a] = tbl[i].wd;
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
`ifdef REGFILE_DBG_DUMP_EN
         d = 1'b0;
`else
         d = 1'($urandom);
`endif
         a = 5'($urandom);
         wd = $urandom;
         xact(w, d, a, wd, $urandom_range(0, 3),
              $urandom_range(0, 2), rd, rl, lat, wn);
         chk("rnd_data", rd, (w ? (a == 0 ? 32'd0 : wd) : ref_rd(a)));
         chk("rnd_last", rl, 1'b1);
         chk("rnd_we", wn, (w && a != 0) ? 1 : 0);
         if (w && a != 0) ref_rf[a] = wd;
      end

      // Reset during the ACCESS cycle of a write x5=7.
      req_write = 1; req_dump = 0; req_addr = 5; req_wdata = 7;
      req_valid = 1; halt_ack = 1;
      tick();
      req_valid = 0;
      tick();
      chk("acc_we", rf_write_en, 1'b1);
      we0 = we_cnt;
      rst = 1'b1;
      tick();
      chk_reset_outs();
      rst = 1'b0;
      tick();
      chk("rst_no_we", we_cnt - we0, 0);
      xact(0, 0, 5, 0, 0, 0, rd, rl, lat, wn);
      chk("rst_x5", rd, ref_rf[5]);

`ifdef REGFILE_DBG_DUMP_EN
      for (int i = 1; i < 32; i++) begin
         xact(1, 0, 5'(i), 32'(i * 3), 0, 0, rd, rl, lat, wn);
         ref_rf[i] = 32'(i * 3);
      end
      we0 = we_cnt;
      req_write = 1; req_dump = 1; req_addr = 9; req_wdata = 1;
      req_valid = 1; halt_ack = 1;
      tick();
      req_valid = 0;
      for (int i = 0; i < 32; i++) begin
         int cyc = 0;
         while (!rsp_valid && cyc < 16) begin
            if (!halt_req) chk("dump_halt", halt_req, 1'b1);
            tick();
            cyc++;
         end
         chk("dump_valid", rsp_valid, 1'b1);
         chk("dump_addr", rsp_addr, 5'(i));
         chk("dump_data", rsp_data, 32'(i * 3));
         chk("dump_last", rsp_last, (i == 31));
         halt_ack = 1'($urandom);
         repeat ($urandom_range(0, 1)) tick();
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         if (i < 31)
            chk("dump_hold", {halt_req, req_ready}, 2'b10);
      end
      chk("dump_end", {rsp_valid, halt_req, req_ready}, 3'b001);
      chk("dump_no_we", we_cnt - we0, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
